regfile_write_arbiter: RTL

Shares the single write port of the MIPS register file (`Registers`) between two writeback requesters: the ALU result path and the memory-load path. Each requester gets a valid/ready handshake. The block registers the granted write and drives `write`/`WriteRegister`/`WriteData` into `Registers`. It also checks decode-stage reads against the in-flight write and either flags a hazard or forwards the data.

---
 rtl/regfile_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/regfile_write_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Default data width, index width, register-zero index and source encoding.
package regfile_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grants are combinational.
// last_grant records the most recent winner and decides ties.
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_mem,
  output logic grant_alu,
  output logic grant_mem,
  output src_t last_grant
);

  // A tie goes to whichever source did not win last time.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst) begin
      if (req_alu && req_mem) begin
        grant_mem = (last_grant == SRC_ALU);
        grant_alu = (last_grant == SRC_MEM);
      end else begin
        grant_alu = req_alu;
        grant_mem = req_mem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_ALU;
    end else if (grant_alu) begin
      last_grant <= SRC_ALU;
    end else if (grant_mem) begin
      last_grant <= SRC_MEM;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback.
// REGFILE_ARB_BYPASS_EN: forward in-flight write data instead of flagging a hazard.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = regfile_arb_pkg::DATA_W,
  parameter int ADDR_W = regfile_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AluValid,
  output logic              AluReady,
  input  logic [ADDR_W-1:0] AluReg,
  input  logic [DATA_W-1:0] AluData,
  input  logic              MemValid,
  output logic              MemReady,
  input  logic [ADDR_W-1:0] MemReg,
  input  logic [DATA_W-1:0] MemData,
  output logic              write,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [DATA_W-1:0] RfData1,
  input  logic [DATA_W-1:0] RfData2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Hazard
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  src_t last_grant;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_alu    (AluValid),
    .req_mem    (MemValid),
    .grant_alu  (AluReady),
    .grant_mem  (MemReady),
    .last_grant (last_grant)
  );

  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  assign sel_reg  = MemReady ? MemReg  : AluReg;
  assign sel_data = MemReady ? MemData : AluData;

  // Register-0 writes are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      write         <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (AluReady || MemReady) begin
      write         <= (sel_reg != ZERO_IDX);
      WriteRegister <= sel_reg;
      WriteData     <= sel_data;
    end else begin
      write <= 1'b0;
    end
  end

  logic [ADDR_W-1:0] rd_reg  [2];
  logic [DATA_W-1:0] rf_data [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [1:0]        match;

  assign rd_reg[0]  = ReadRegister1;
  assign rd_reg[1]  = ReadRegister2;
  assign rf_data[0] = RfData1;
  assign rf_data[1] = RfData2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      assign match[gi] = write && (rd_reg[gi] == WriteRegister) && (rd_reg[gi] != ZERO_IDX);
`ifdef REGFILE_ARB_BYPASS_EN
      assign rd_data[gi] = match[gi] ? WriteData : rf_data[gi];
`else
      assign rd_data[gi] = rf_data[gi];
`endif
    end
  endgenerate

  assign ReadData1 = rd_data[0];
  assign ReadData2 = rd_data[1];

`ifdef REGFILE_ARB_BYPASS_EN
  assign Hazard = 1'b0;
`else
  assign Hazard = |match;
`endif

endmodule
